// File: rtl/tcam_pkg.sv
// tcam_pkg: shared types and constants for the TCAM command scheduler.
//   op_e    : upstream request opcodes
//   MODE_*  : TCAM wrapper MODE encodings
//   state_e : scheduler FSM states
package tcam_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_LOOKUP = 2'd1,
    OP_WRITE  = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  localparam logic [2:0] MODE_I   = 3'd0;
  localparam logic [2:0] MODE_W   = 3'd1;
  localparam logic [2:0] MODE_R   = 3'd2;
  localparam logic [2:0] MODE_F   = 3'd3;
  localparam logic [2:0] MODE_C   = 3'd4;
  localparam logic [2:0] MODE_RST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/tcam_stats_cnt.sv
// tcam_stats_cnt: one 16-bit event counter that saturates at 16'hFFFF.
//   clk, rst : clock, async active-high reset (clears the count)
//   inc      : count one event this cycle
//   cnt      : current count
module tcam_stats_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tcam_cmd_sched.sv
// tcam_cmd_sched: upstream command scheduler for the TCAM wrapper.
// Accepts LOOKUP/WRITE/FLUSH/NOP on a valid/ready port, serialises each into
// the wrapper MODE/data signals, times the compare->DstID latency and
// returns {id, dst, hit} on a valid/ready response port. One op in flight.
//   clk, rst           : clock, async active-high reset
//   req_*              : request port (op, id/key, write data/mask/vbi/addr)
//   MODE .. Vbi_Out    : drive the TCAM wrapper inputs
//   DstID_In           : wrapper match result (0 = miss)
//   rsp_*              : lookup response port
// Optional: define TCAM_SCHED_STATS_EN to add saturating stat_lookups,
// stat_hits and stat_flushes outputs.
module tcam_cmd_sched
  import tcam_pkg::*;
#(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int LOOKUP_LAT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [ID_Width-1:0]    req_id,
  input  logic [Bits-1:0]        req_data,
  input  logic [Bits-1:0]        req_mskb,
  input  logic                   req_vbi,
  input  logic [AddressSize-1:0] req_addr,
  output logic [2:0]             MODE,
  output logic [ID_Width-1:0]    PacketID_Out,
  output logic [Bits-1:0]        Data_Out,
  output logic [Bits-1:0]        Mskb_Out,
  output logic [AddressSize-1:0] A_Out,
  output logic                   Vbe_Out,
  output logic                   Dcs_Out,
  output logic                   Vbi_Out,
  input  logic [ID_Width-1:0]    DstID_In,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_Width-1:0]    rsp_id,
  output logic [ID_Width-1:0]    rsp_dst,
  output logic                   rsp_hit
`ifdef TCAM_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_lookups,
  output logic [15:0]            stat_hits,
  output logic [15:0]            stat_flushes
`endif
);

  localparam int CW = $clog2(LOOKUP_LAT + 1);

  if (LOOKUP_LAT < 2) begin : g_lat_chk
    $error("tcam_cmd_sched: LOOKUP_LAT must be >= 2");
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   req_ready_q, req_ready_d;
  op_e                    op_q, op_d;
  logic [ID_Width-1:0]    id_q, id_d;
  logic [Bits-1:0]        data_q, data_d;
  logic [Bits-1:0]        mskb_q, mskb_d;
  logic                   vbi_q, vbi_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic [ID_Width-1:0]    rsp_dst_q, rsp_dst_d;
  logic                   rsp_hit_q, rsp_hit_d;

  logic accept;
  logic sample;

  assign accept = req_valid && req_ready_q;
  // DstID_In is valid in the last WAIT cycle
  assign sample = (state_q == ST_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    id_d      = id_q;
    data_d    = data_q;
    mskb_d    = mskb_q;
    vbi_d     = vbi_q;
    addr_d    = addr_q;
    rsp_dst_d = rsp_dst_q;
    rsp_hit_d = rsp_hit_q;

    case (state_q)
      ST_IDLE: begin
        // NOP is consumed without touching the held wrapper fields
        if (accept && (op_e'(req_op) != OP_NOP)) begin
          op_d    = op_e'(req_op);
          id_d    = req_id;
          data_d  = req_data;
          mskb_d  = req_mskb;
          vbi_d   = req_vbi;
          addr_d  = req_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_LOOKUP) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(LOOKUP_LAT - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sample) begin
          rsp_dst_d = DstID_In;
          rsp_hit_d = (DstID_In != '0);
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered ready: follows the state we are about to be in, so it
    // first rises on the edge after reset is released.
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      op_q        <= OP_NOP;
      id_q        <= '0;
      data_q      <= '0;
      mskb_q      <= '0;
      vbi_q       <= 1'b0;
      addr_q      <= '0;
      rsp_dst_q   <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      op_q        <= op_d;
      id_q        <= id_d;
      data_q      <= data_d;
      mskb_q      <= mskb_d;
      vbi_q       <= vbi_d;
      addr_q      <= addr_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  logic issue_wr;
  assign issue_wr = (state_q == ST_ISSUE) && (op_q == OP_WRITE);

  always_comb begin
    MODE = MODE_I;
    if (state_q == ST_ISSUE) begin
      case (op_q)
        OP_LOOKUP: MODE = MODE_C;
        OP_WRITE:  MODE = MODE_W;
        OP_FLUSH:  MODE = MODE_F;
        default:   MODE = MODE_I;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign PacketID_Out = id_q;
  assign Data_Out     = data_q;
  assign Mskb_Out     = mskb_q;
  assign A_Out        = addr_q;
  assign Vbe_Out      = issue_wr;
  assign Dcs_Out      = issue_wr;
  assign Vbi_Out      = issue_wr && vbi_q;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = id_q;
  assign rsp_dst      = rsp_dst_q;
  assign rsp_hit      = rsp_hit_q;

`ifdef TCAM_SCHED_STATS_EN
  logic inc_lookup, inc_hit, inc_flush;
  assign inc_lookup = accept && (op_e'(req_op) == OP_LOOKUP);
  assign inc_hit    = sample && (DstID_In != '0);
  assign inc_flush  = (state_q == ST_ISSUE) && (op_q == OP_FLUSH);

  tcam_stats_cnt u_cnt_lookups (.clk(clk), .rst(rst), .inc(inc_lookup), .cnt(stat_lookups));
  tcam_stats_cnt u_cnt_hits    (.clk(clk), .rst(rst), .inc(inc_hit),    .cnt(stat_hits));
  tcam_stats_cnt u_cnt_flushes (.clk(clk), .rst(rst), .inc(inc_flush),  .cnt(stat_flushes));
`endif

endmodule

// File: tb/tb_tcam_cmd_sched.sv
// tb_tcam_cmd_sched: self-checking bench for tcam_cmd_sched.
// Directed vector table, a reset-mid-lookup sequence, then randomized ops
// checked against a transaction-level timeline model.
// Define TCAM_SCHED_STATS_EN to also check the statistics counters.
module tb_tcam_cmd_sched;
  import tcam_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [3:0] req_id = '0;
  logic [7:0] req_data = '0;
  logic [7:0] req_mskb = '0;
  logic       req_vbi = 1'b0;
  logic [3:0] req_addr = '0;
  logic [2:0] MODE;
  logic [3:0] PacketID_Out;
  logic [7:0] Data_Out, Mskb_Out;
  logic [3:0] A_Out;
  logic       Vbe_Out, Dcs_Out, Vbi_Out;
  logic [3:0] DstID_In = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_id, rsp_dst;
  logic       rsp_hit;
`ifdef TCAM_SCHED_STATS_EN
  logic [15:0] stat_lookups, stat_hits, stat_flushes;
`endif

  tcam_cmd_sched #(.ID_Width(4), .AddressSize(4), .Bits(8), .LOOKUP_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .req_data(req_data), .req_mskb(req_mskb), .req_vbi(req_vbi), .req_addr(req_addr),
    .MODE(MODE), .PacketID_Out(PacketID_Out), .Data_Out(Data_Out), .Mskb_Out(Mskb_Out),
    .A_Out(A_Out), .Vbe_Out(Vbe_Out), .Dcs_Out(Dcs_Out), .Vbi_Out(Vbi_Out),
    .DstID_In(DstID_In), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_dst(rsp_dst), .rsp_hit(rsp_hit)
`ifdef TCAM_SCHED_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_flushes(stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] id;
    logic [7:0] data;
    logic [7:0] mskb;
    logic       vbi;
    logic [3:0] addr;
    logic [3:0] dst;
    int         stall;
    logic [2:0] exp_mode;
    logic       exp_hit;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int m_lookups = 0, m_hits = 0, m_flushes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wrapper MODE code the spec assigns to each request kind
  function automatic logic [2:0] mode_of(input logic [1:0] op);
    case (op)
      2'd1:    return 3'd4;
      2'd2:    return 3'd1;
      2'd3:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // Issue one request from a negedge and follow the spec timeline to the
  // end of the transaction; returns at a negedge with the DUT back in IDLE.
  task automatic send(input vec_t v);
    int n;
    req_valid = 1'b1; req_op = v.op; req_id = v.id; req_data = v.data;
    req_mskb = v.mskb; req_vbi = v.vbi; req_addr = v.addr;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (v.op == OP_LOOKUP) m_lookups++;
    @(negedge clk);  // T+1
    req_valid = 1'b0; req_op = '0;
    chk("issue_mode", 32'(MODE), 32'(v.exp_mode));
    if (v.op == OP_NOP) begin
      chk("nop_ready", 32'(req_ready), 32'd1);
      return;
    end
    chk("issue_id", 32'(PacketID_Out), 32'(v.id));
    chk("issue_ready", 32'(req_ready), 32'd0);
    if (v.op == OP_WRITE) begin
      chk("wr_data", 32'(Data_Out), 32'(v.data));
      chk("wr_mskb", 32'(Mskb_Out), 32'(v.mskb));
      chk("wr_addr", 32'(A_Out), 32'(v.addr));
      chk("wr_vbe_dcs_vbi", 32'({Vbe_Out, Dcs_Out, Vbi_Out}), 32'({2'b11, v.vbi}));
    end else begin
      chk("nonwr_vbe_dcs", 32'({Vbe_Out, Dcs_Out}), 32'd0);
    end
    if (v.op == OP_FLUSH) m_flushes++;
    if (v.op != OP_LOOKUP) begin
      @(negedge clk);  // T+2
      chk("post_mode", 32'(MODE), 32'd0);
      chk("post_ready", 32'(req_ready), 32'd1);
      chk("post_norsp", 32'(rsp_valid), 32'd0);
      return;
    end
    DstID_In = ~v.dst;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) DstID_In = v.dst;  // only value present at T+1+LAT
      chk("wait_mode", 32'(MODE), 32'd0);
      chk("wait_rsp", 32'({rsp_valid, req_ready}), 32'd0);
    end
    @(negedge clk);  // T+5
    DstID_In = ~v.dst;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_dst", 32'(rsp_dst), 32'(v.dst));
    chk("rsp_hit", 32'(rsp_hit), 32'(v.exp_hit));
    if (v.exp_hit) m_hits++;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      DstID_In = 4'($urandom);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_fields", 32'({rsp_id, rsp_dst, rsp_hit}), 32'({v.id, v.dst, v.exp_hit}));
      chk("stall_mode_ready", 32'({MODE, req_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_done_ready", 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{2'd2, 4'h2, 8'hA0, 8'hF0, 1'b1, 4'h3, 4'h0, 0,  3'd1, 1'b0};
    tbl[1] = '{2'd1, 4'hA, 8'h00, 8'h00, 1'b0, 4'h0, 4'h3, 0,  3'd4, 1'b1};
    tbl[2] = '{2'd1, 4'h5, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 0,  3'd4, 1'b0};
    tbl[3] = '{2'd1, 4'h7, 8'h11, 8'h22, 1'b0, 4'h1, 4'h9, 10, 3'd4, 1'b1};
    tbl[4] = '{2'd0, 4'h1, 8'h33, 8'h44, 1'b1, 4'h2, 4'h0, 0,  3'd0, 1'b0};
    tbl[5] = '{2'd3, 4'h6, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 0,  3'd3, 1'b0};
    tbl[6] = '{2'd1, 4'hC, 8'h00, 8'h00, 1'b0, 4'h0, 4'h6, 2,  3'd4, 1'b1};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_mode", 32'(MODE), 32'd0);
    chk("rst_outs", 32'({rsp_valid, req_ready, Vbe_Out, Dcs_Out, Vbi_Out}), 32'd0);
    chk("rst_fields", 32'({PacketID_Out, Data_Out, A_Out}), 32'd0);
    rst = 1'b0;
    chk("rst_rel_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rst_rel_ready1", 32'(req_ready), 32'd1);

    // Reset asserted while a lookup is in WAIT: no response afterwards
    req_valid = 1'b1; req_op = 2'd1; req_id = 4'h3;
    @(negedge clk); req_valid = 1'b0; req_op = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mode", 32'(MODE), 32'd0);
    chk("midrst_outs", 32'({rsp_valid, req_ready}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_lookups = 0; m_hits = 0; m_flushes = 0;
    chk("midrst_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("midrst_ready1", 32'(req_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_norsp", 32'({rsp_valid, MODE}), 32'd0);
    end

    // Directed vectors; entries 5 and 6 run FLUSH then LOOKUP back-to-back
    for (int i = 0; i < 7; i++) send(tbl[i]);

`ifdef TCAM_SCHED_STATS_EN
    chk("stat_lookups_dir", 32'(stat_lookups), 32'(m_lookups));
    chk("stat_flushes_dir", 32'(stat_flushes), 32'(m_flushes));
`endif

    // Randomized ops against the timeline model
    for (int i = 0; i < 60; i++) begin
      rv.op    = 2'($urandom_range(0, 3));
      rv.id    = 4'($urandom);
      rv.data  = 8'($urandom);
      rv.mskb  = 8'($urandom);
      rv.vbi   = 1'($urandom);
      rv.addr  = 4'($urandom);
      rv.dst   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rv.stall = $urandom_range(0, 3);
      rv.exp_mode = mode_of(rv.op);
      rv.exp_hit  = (rv.dst != 4'h0);
      send(rv);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

`ifdef TCAM_SCHED_STATS_EN
    chk("stat_lookups", 32'(stat_lookups), 32'(m_lookups));
    chk("stat_hits", 32'(stat_hits), 32'(m_hits));
    chk("stat_flushes", 32'(stat_flushes), 32'(m_flushes));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
